// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// port IDs and default timing parameters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with zero flag; times the WAIT phase of an access.
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch (I)
// and data (D) ports. Each access runs IDLE -> ISSUE -> WAIT -> RESP.
// D has fixed priority. Define MEM_ARB_STARVE_GUARD_EN to force an I grant
// once I has waited STARVE_MAX cycles behind D accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  arb_state_e state, state_n;
  logic       op_we;
  logic       grant_i, grant_d, force_i, cnt_zero;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SC_W = cnt_width(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_cnt;

  assign force_i = i_req && (starve_cnt == SC_W'(STARVE_MAX));

  // Count I wait cycles behind a D access; cleared by any I grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (grant_i)
      starve_cnt <= '0;
    else if (busy && owner_d == PORT_D && i_req && starve_cnt != SC_W'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_i = 1'b0;
`endif

  // Arbitration only happens in IDLE; D wins unless the starve guard fires.
  assign grant_d = (state == ST_IDLE) && d_req && !force_i;
  assign grant_i = (state == ST_IDLE) && i_req && (force_i || !d_req);
  assign busy    = (state != ST_IDLE);

  arb_lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_ISSUE),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .dec      (state == ST_WAIT),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (grant_i || grant_d) state_n = ST_ISSUE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_n = ST_RESP;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Registered memory strobes, grant ownership, acks and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      op_we     <= 1'b0;
      owner_d   <= PORT_I;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_d) begin
        owner_d   <= PORT_D;
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        op_we     <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        owner_d   <= PORT_I;
        mem_en    <= 1'b1;
        op_we     <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
      if (state == ST_WAIT && cnt_zero) begin
        if (owner_d == PORT_D) begin
          d_ack   <= 1'b1;
          d_rdata <= op_we ? '0 : mem_rdata;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MEM_LAT=1 instance with a
// read/write memory model and a MEM_LAT=3 read-only instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [9:0]  i_addr, d_addr, mem_addr;
  logic [31:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_en, mem_we, busy, owner_d;

  logic        i_req3, d_req3, d_we3;
  logic [9:0]  i_addr3, d_addr3, mem_addr3;
  logic [31:0] d_wdata3, i_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic        i_ack3, d_ack3, mem_en3, mem_we3, busy3, owner_d3;

  logic [31:0] mem [1024];
  logic [31:0] p3 [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner_d(owner_d)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .busy(busy3), .owner_d(owner_d3)
  );

  // Synchronous memory, one-cycle read latency, for the MEM_LAT=1 instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // Three-cycle read pipeline for the MEM_LAT=3 instance.
  always @(posedge clk) begin
    if (mem_en3) p3[0] <= mem[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  // One single-port transaction on the MEM_LAT=1 instance; cycle 1 is the
  // first cycle after the grant edge.
  task automatic run_txn(input bit d, input bit we, input logic [9:0] addr,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd, output bit other,
                         output int en_cnt, output int en_cyc,
                         output bit we_at, output logic [9:0] addr_at);
    bit done = 0;
    lat = 0; rd = '0; other = 0; en_cnt = 0; en_cyc = 0; we_at = 0; addr_at = '0;
    wait_idle();
    if (d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else   begin i_req = 1; i_addr = addr; end
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); #1;
      if (mem_en) begin en_cnt++; en_cyc = c; we_at = mem_we; addr_at = mem_addr; end
      if (d ? i_ack : d_ack) other = 1;
      if (d ? d_ack : i_ack) begin
        lat = c; rd = d ? d_rdata : i_rdata; done = 1;
      end
    end
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  typedef struct {
    bit          d;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, en_cnt, en_cyc, d_cyc, i_cyc, bcnt, first_i;
    logic [31:0] rd;
    logic [9:0]  addr_at;
    bit other, we_at, ack_seen, busy_at_ack;

    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    mem[4] <= 32'h2002_0005;

    vecs[0] = '{0, 0, 10'h004, 32'h0,         32'h2002_0005};
    vecs[1] = '{1, 1, 10'h010, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1, 0, 10'h010, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{0, 0, 10'h010, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1, 1, 10'h3FF, 32'h1234_5678, 32'h0};
    vecs[5] = '{0, 0, 10'h3FF, 32'h0,         32'h1234_5678};
    vecs[6] = '{1, 0, 10'h000, 32'h0,         32'hA5A5_0000};

    reset = 0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req3 = 0; i_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;

    // Reset state: every output zero on both instances.
    #12;
    chk("reset_outs", {i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr,
                       mem_wdata, busy, owner_d}, '0);
    chk("reset_outs3", {i_ack3, d_ack3, i_rdata3, d_rdata3, mem_en3, busy3, owner_d3}, '0);
    @(negedge clk); reset = 1;

    // Single-port accesses from the table.
    foreach (vecs[k]) begin
      run_txn(vecs[k].d, vecs[k].we, vecs[k].addr, vecs[k].wdata,
              lat, rd, other, en_cnt, en_cyc, we_at, addr_at);
      chk($sformatf("v%0d_ack_latency", k), lat, 3);
      chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp);
      chk($sformatf("v%0d_other_ack", k), other, 0);
      chk($sformatf("v%0d_mem_en_cycle", k), {en_cnt, en_cyc}, {32'd1, 32'd1});
      chk($sformatf("v%0d_mem_we_addr", k), {we_at, addr_at}, {vecs[k].we, vecs[k].addr});
      chk($sformatf("v%0d_owner_d", k), owner_d, vecs[k].d);
    end
    chk("mem_holds_write", mem[10'h010], 32'hDEAD_BEEF);

    // Simultaneous requests: D first, then I at the next IDLE.
    wait_idle();
    d_req = 1; d_we = 0; d_addr = 10'h030; i_req = 1; i_addr = 10'h004;
    d_cyc = 0; i_cyc = 0; en_cnt = 0; other = 0;
    for (int c = 1; c <= 20 && i_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        en_cnt++;
        if (en_cnt == 2 && c < 5) other = 1;
      end
      if (d_ack) begin
        d_cyc = c; d_req = 0;
        chk("both_d_rdata", d_rdata, 32'hA5A5_0030);
      end
      if (i_ack) begin
        i_cyc = c; i_req = 0;
        chk("both_i_rdata", i_rdata, 32'h2002_0005);
      end
    end
    i_req = 0; d_req = 0;
    chk("both_d_ack_cycle", d_cyc, 3);
    chk("both_i_ack_cycle", i_cyc, 7);
    chk("both_mem_en_count", en_cnt, 2);
    chk("both_mem_en_overlap", other, 0);

    // MEM_LAT=3 D read on the second instance.
    @(negedge clk);
    d_req3 = 1; d_addr3 = 10'h020;
    lat = 0; bcnt = 0; busy_at_ack = 0; rd = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (d_ack3) begin lat = c; rd = d_rdata3; busy_at_ack = busy3; end
      else if (busy3) bcnt++;
    end
    d_req3 = 0;
    chk("lat3_ack_cycle", lat, 5);
    chk("lat3_busy_before_ack", bcnt, 4);
    chk("lat3_busy_in_resp", busy_at_ack, 1);
    chk("lat3_rdata", rd, 32'hA5A5_0020);

    // Reset asserted during WAIT abandons the access.
    wait_idle();
    i_req = 1; i_addr = 10'h040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_busy_before", busy, 1);
    reset = 0; i_req = 0;
    #1;
    chk("rst_mid_outs", {i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr,
                         mem_wdata, busy, owner_d}, '0);
    @(negedge clk); reset = 1;
    ack_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (i_ack || d_ack || busy) ack_seen = 1;
    end
    chk("rst_mid_no_ack", ack_seen, 0);
    run_txn(0, 0, 10'h040, 32'h0, lat, rd, other, en_cnt, en_cyc, we_at, addr_at);
    chk("rst_after_latency", lat, 3);
    chk("rst_after_rdata", rd, 32'hA5A5_0040);

    // D held continuously with I pending.
    wait_idle();
    d_req = 1; d_we = 0; d_addr = 10'h000; i_req = 1; i_addr = 10'h004;
    first_i = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (i_ack && first_i == 0) begin
        first_i = c; i_req = 0;
        chk("starve_i_rdata", i_rdata, 32'h2002_0005);
      end
    end
    @(negedge clk);
    d_req = 0; i_req = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_guard_grant", (first_i > 0 && first_i <= 11), 1);
`else
    chk("no_guard_i_blocked", first_i, 0);
`endif
    run_txn(0, 0, 10'h004, 32'h0, lat, rd, other, en_cnt, en_cyc, we_at, addr_at);
    chk("after_starve_latency", lat, 3);
    chk("after_starve_rdata", rd, 32'h2002_0005);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
